airi5c_div_unit: RTL and testbench

//  Iterative RV32M divider: DIV, DIVU, REM, REMU. Sits beside the single-cycle ALU in EX.
//  EX drives operands and op, then stalls on a valid/ready handshake until the result returns.

---
 rtl/airi5c_div_unit.sv | 140 ++++++++++++++
 tb/tb_airi5c_div_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient bit per clock,
// with a single-cycle path for divide-by-zero and signed overflow.
module airi5c_div_unit #(
    parameter int unsigned XPR_LEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               kill_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [1:0]         op_i,
    input  logic [XPR_LEN-1:0] in1_i,
    input  logic [XPR_LEN-1:0] in2_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [XPR_LEN-1:0] out_o,
    output logic               busy_o
);

    localparam int unsigned CW = $clog2(XPR_LEN + 1);
    localparam logic [XPR_LEN-1:0] MIN_NEG = {1'b1, {(XPR_LEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [XPR_LEN-1:0] rem_q, rem_d;
    logic [XPR_LEN-1:0] quo_q, quo_d;
    logic [XPR_LEN-1:0] dvsr_q, dvsr_d;
    logic               rem_sel_q, rem_sel_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [XPR_LEN-1:0] res_d;

    logic               sign1, sign2;
    logic [XPR_LEN-1:0] abs1, abs2;
    logic [XPR_LEN:0]   rem_sh, diff;
    logic [XPR_LEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

    // Operand magnitudes at accept; signed ops use two's-complement magnitude.
    assign sign1 = ~op_i[0] & in1_i[XPR_LEN-1];
    assign sign2 = ~op_i[0] & in2_i[XPR_LEN-1];
    assign abs1  = sign1 ? -in1_i : in1_i;
    assign abs2  = sign2 ? -in2_i : in2_i;

    // One restoring step on the {rem,quo} pair, plus the sign fix used when leaving CALC.
    assign rem_sh = {rem_q, quo_q[XPR_LEN-1]};
    assign diff   = rem_sh - {1'b0, dvsr_q};
    assign rem_nx = diff[XPR_LEN] ? rem_sh[XPR_LEN-1:0] : diff[XPR_LEN-1:0];
    assign quo_nx = {quo_q[XPR_LEN-2:0], ~diff[XPR_LEN]};
    assign q_fix  = neg_quo_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_rem_q ? -rem_nx : rem_nx;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = out_o;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rem_sel_d = op_i[1];
                    neg_quo_d = sign1 ^ sign2;
                    neg_rem_d = sign1;
                    if (in2_i == '0) begin
                        state_d = DONE;
                        res_d   = op_i[1] ? in1_i : '1;
                    end else if (!op_i[0] && in1_i == MIN_NEG && in2_i == '1) begin
                        state_d = DONE;
                        res_d   = op_i[1] ? '0 : in1_i;
                    end else begin
                        state_d = CALC;
                        count_d = CW'(XPR_LEN);
                        rem_d   = '0;
                        quo_d   = abs1;
                        dvsr_d  = abs2;
                    end
                end
            end
            CALC: begin
                rem_d   = rem_nx;
                quo_d   = quo_nx;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = rem_sel_q ? r_fix : q_fix;
                end
            end
            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                    res_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides accept and response handshake.
        if (kill_i) begin
            state_d = IDLE;
            count_d = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            rem_sel_q    <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            resp_valid_o <= 1'b0;
            out_o        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvsr_q       <= dvsr_d;
            rem_sel_q    <= rem_sel_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            req_ready_o  <= (state_d == IDLE);
            busy_o       <= (state_d != IDLE);
            resp_valid_o <= (state_d == DONE);
            out_o        <= (state_d == DONE) ? res_d : '0;
        end
    end

endmodule

// File: tb/tb_airi5c_div_unit.sv
// Self-checking bench for airi5c_div_unit: directed RV32M cases, special cases, hold,
// kill, reset and randomized operations against a plain-arithmetic reference model.
module tb_airi5c_div_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        kill_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] in1_i = '0;
    logic [31:0] in2_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] out_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    airi5c_div_unit #(.XPR_LEN(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .kill_i(kill_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_i(op_i), .in1_i(in1_i), .in2_i(in2_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .out_o(out_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // RISC-V M-extension semantics expressed with native arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || resp_valid_o !== 1'b0 || out_o !== 32'd0) begin
            errors++;
            $display("FAIL %s: rdy=%b busy=%b vld=%b out=%h, required rdy=1 busy=0 vld=0 out=0",
                     name, req_ready_o, busy_o, resp_valid_o, out_o);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid_i = 1'b1;
        op_i = op; in1_i = a; in2_i = b;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic release_resp(input string name);
        @(negedge clk);
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        check_idle(name);
    endtask

    // Accept, wait for the response counting edges after the accept, check latency and value.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit do_release);
        int lat;
        int exp_lat;
        exp_lat = model_lat(op, a, b);
        start_op(op, a, b);
        lat = 0;
        if (!resp_valid_o) begin
            checks++;
            if (req_ready_o !== 1'b0 || busy_o !== 1'b1 || out_o !== 32'd0) begin
                errors++;
                $display("FAIL %s calc: rdy=%b busy=%b out=%h, required rdy=0 busy=1 out=0",
                         name, req_ready_o, busy_o, out_o);
            end
        end
        while (!resp_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (out_o !== exp) begin
            errors++;
            $display("FAIL %s value: got %h, required %h", name, out_o, exp);
        end
        if (do_release) release_resp({name, " release"});
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b1);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    endtask

    task automatic test_special();
        run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_by_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op("rem_neg_by_zero", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
        run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        run_op("divu_no_overflow", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    endtask

    task automatic test_hold();
        logic [31:0] held;
        int bad;
        run_op("hold_divu", OP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b0);
        held = out_o;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid_o !== 1'b1 || out_o !== held || req_ready_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        end
        release_resp("hold_release");
    endtask

    task automatic test_kill();
        int seen;
        start_op(OP_DIVU, 32'd12345, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check_idle("kill_calc");
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL kill_no_resp: resp_valid seen %0d cycles, required 0", seen);
        end
        @(negedge clk);
        kill_i = 1'b1;
        req_valid_i = 1'b1;
        op_i = OP_DIV; in1_i = 32'd5; in2_i = 32'd0;
        @(posedge clk); #1;
        kill_i = 1'b0;
        req_valid_i = 1'b0;
        check_idle("kill_accept");
        repeat (3) @(posedge clk);
        #1;
        check_idle("kill_accept_dropped");
    endtask

    task automatic test_rst_mid();
        start_op(OP_DIVU, 32'd999, 32'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_idle("rst_calc");
        @(negedge clk);
        rst_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_idle("rst_calc_no_resp");
        run_op("rst_done_op", OP_DIVU, 32'd50, 32'd5, 32'd10, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_idle("rst_done");
        @(negedge clk);
        rst_i = 1'b0;
        run_op("after_rst_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1);
    endtask

    // Request held high across the response handshake must not be taken in that cycle.
    task automatic test_back_to_back();
        run_op("b2b_first", OP_DIVU, 32'd77, 32'd0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        resp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        op_i = OP_REMU; in1_i = 32'd77; in2_i = 32'd0;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        check_idle("b2b_handshake");
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b1 || out_o !== 32'd77) begin
            errors++;
            $display("FAIL b2b_second: vld=%b out=%h, required vld=1 out=0000004d", resp_valid_o, out_o);
        end
        release_resp("b2b_second_release");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_hold();
        test_kill();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
